uart_rx_ctrl: RTL and testbench

Receive-side controller for the UART receiver. It generates the 16x oversampling `tick` from a programmable divisor and gates it with an enable/drain state machine. It captures each completed frame (`rx_done`, `rx_data`, `rx_error`) into a show-ahead FIFO and presents frames downstream on a valid/ready handshake with overrun and parity-error bookkeeping. It sits between the UART receiver and the register/bus side of the design.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_fifo.sv | 53 +++++
 rtl/uart_rx_ctrl.sv | 93 +++++++++
 tb/tb_uart_rx_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receive-side blocks.
//   ctrl_state_e : receive controller state (IDLE, RUN, DRAIN)
//   rx_entry_t   : FIFO entry layout {perr, data} at the default data width
//   ERR_CNT_W    : width of the saturating parity-error counter
package uart_pkg;
   localparam int ERR_CNT_W = 8;
   localparam int DATA_W = 8;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} ctrl_state_e;
   typedef struct packed {
      logic perr;
      logic [DATA_W-1:0] data;
   } rx_entry_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous show-ahead FIFO for received frames.
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : write an entry (caller guarantees room or a same-cycle pop)
//   pop           : remove the head entry (ignored when empty)
//   flush         : empty the FIFO; overrides push and pop
//   rdata         : head entry, zero while empty
//   count, full, empty : occupancy
module uart_rx_fifo #(
   parameter int W = 9,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          pop_ok;
   always_comb begin
      pop_ok   = pop && !empty;
      wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
      rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop_ok);
      count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop_ok);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
   // storage is not reset; the empty mask keeps the head at zero instead
   always_ff @(posedge clk)
      if (push && !flush) mem_q[wr_ptr_q] <= wdata;
   assign empty = count_q == '0;
   assign full  = count_q == CW'(DEPTH);
   assign count = count_q;
   assign rdata = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller - tick divider, enable/drain FSM, frame FIFO.
//   clk, rst                 : clock, synchronous active-high reset
//   enable, baud_div         : run request and tick period minus one
//   flush, clr_overrun       : FIFO flush and overrun-clear pulses
//   tick                     : registered oversampling strobe to the receiver
//   rx_done, rx_data, rx_error : completed frame from the receiver
//   out_valid/out_data/out_perr/out_ready : downstream handshake
//   fifo_count, overrun      : occupancy and sticky drop flag
//   err_cnt                  : saturating parity-error count, only with UART_RX_ERR_CNT_EN
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int DEPTH = 8,
   parameter int DIV_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic [DIV_W-1:0]           baud_div,
   input  logic                       flush,
   input  logic                       clr_overrun,
   output logic                       tick,
   input  logic                       rx_done,
   input  logic [DATA_BITS-1:0]       rx_data,
   input  logic                       rx_error,
   output logic                       out_valid,
   output logic [DATA_BITS-1:0]       out_data,
   output logic                       out_perr,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     fifo_count,
`ifdef UART_RX_ERR_CNT_EN
   output logic [ERR_CNT_W-1:0]       err_cnt,
`endif
   output logic                       overrun
);
   ctrl_state_e      state_q, state_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             tick_q, tick_d, overrun_q, overrun_d;
   logic             run, hit, pop, push_req, push_ok, drop, full, empty;
   always_comb begin
      state_d = state_q == IDLE ? (enable ? RUN : IDLE) :
                state_q == RUN  ? (enable ? RUN : DRAIN) :
                enable ? RUN : (fifo_count == '0 ? IDLE : DRAIN);
      // gating with enable keeps a falling enable from emitting a last tick
      run       = state_q == RUN && enable;
      hit       = div_cnt_q == baud_div;
      div_cnt_d = run && !hit ? div_cnt_q + 1'b1 : '0;
      tick_d    = run && hit;
      pop       = out_valid && out_ready;
      push_req  = rx_done && state_q == RUN && !flush;
      push_ok   = push_req && (!full || pop);
      drop      = push_req && full && !pop;
      overrun_d = drop ? 1'b1 : clr_overrun ? 1'b0 : overrun_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         div_cnt_q <= '0;
         tick_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         tick_q    <= tick_d;
         overrun_q <= overrun_d;
      end
   end
`ifdef UART_RX_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   always_comb
      err_cnt_d = flush ? '0 : (push_ok && rx_error && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
   always_ff @(posedge clk)
      if (rst) err_cnt_q <= '0;
      else err_cnt_q <= err_cnt_d;
   assign err_cnt = err_cnt_q;
`endif
   uart_rx_fifo #(.W(DATA_BITS + 1), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_ok),
      .pop   (pop),
      .flush (flush),
      .wdata ({rx_error, rx_data}),
      .rdata ({out_perr, out_data}),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );
   assign out_valid = !empty;
   assign tick      = tick_q;
   assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl with a frame scoreboard.
module tb_uart_rx_ctrl;
   import uart_pkg::*;
   localparam int DEPTH = 8;
   logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, flush = 1'b0, clr_overrun = 1'b0;
   logic [15:0] baud_div = 16'd3;
   logic        tick, rx_done = 1'b0, rx_error = 1'b0, out_valid, out_perr, out_ready = 1'b0, overrun;
   logic [7:0]  rx_data = 8'h00, out_data;
   logic [3:0]  fifo_count;
`ifdef UART_RX_ERR_CNT_EN
   logic [7:0]  err_cnt;
`endif
   int          total = 0, bad = 0;
   logic [8:0]  sb [$];
   int          mcount = 0, merr = 0;
   logic        moverrun = 1'b0, mrun = 1'b0;

   uart_rx_ctrl #(.DATA_BITS(8), .DEPTH(DEPTH), .DIV_W(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .baud_div(baud_div), .flush(flush),
      .clr_overrun(clr_overrun), .tick(tick), .rx_done(rx_done), .rx_data(rx_data),
      .rx_error(rx_error), .out_valid(out_valid), .out_data(out_data), .out_perr(out_perr),
      .out_ready(out_ready), .fifo_count(fifo_count),
`ifdef UART_RX_ERR_CNT_EN
      .err_cnt(err_cnt),
`endif
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   // advance one cycle: update the model from the inputs about to be sampled, then compare
   task automatic step();
      logic       pop;
      logic [8:0] exp;
      pop = out_ready && mcount != 0;
      if (rst) begin
         sb.delete();
         mcount = 0; merr = 0; moverrun = 1'b0;
      end else begin
         if (pop) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL pop_unexpected: got %h expected none", {out_perr, out_data});
            end else begin
               exp = sb.pop_front();
               if ({out_perr, out_data} !== exp) begin
                  bad++;
                  $display("FAIL pop_data: got %h expected %h", {out_perr, out_data}, exp);
               end
            end
         end
         if (flush) begin
            sb.delete();
            mcount = 0; merr = 0;
            pop = 1'b0;
         end else if (rx_done && mrun) begin
            if (mcount < DEPTH || pop) begin
               sb.push_back({rx_error, rx_data});
               mcount++;
               if (rx_error && merr < 255) merr++;
            end else moverrun = 1'b1;
         end
         if (pop) mcount--;
         if (clr_overrun && !(rx_done && mrun && !flush && mcount == DEPTH && !pop)) moverrun = 1'b0;
      end
      @(posedge clk);
      #1;
      total++;
      if (fifo_count !== 4'(mcount)) begin
         bad++;
         $display("FAIL fifo_count: got %0d expected %0d", fifo_count, mcount);
      end
      total++;
      if (out_valid !== (mcount != 0)) begin
         bad++;
         $display("FAIL out_valid: got %b expected %b", out_valid, mcount != 0);
      end
      total++;
      if (overrun !== moverrun) begin
         bad++;
         $display("FAIL overrun: got %b expected %b", overrun, moverrun);
      end
`ifdef UART_RX_ERR_CNT_EN
      total++;
      if (err_cnt !== 8'(merr)) begin
         bad++;
         $display("FAIL err_cnt: got %0d expected %0d", err_cnt, merr);
      end
`endif
   endtask

   task automatic send(input logic [7:0] d, input logic e);
      rx_done = 1'b1; rx_data = d; rx_error = e;
      step();
      rx_done = 1'b0; rx_error = 1'b0;
   endtask

   task automatic check_state(input string name, input ctrl_state_e exp);
      total++;
      if (dut.state_q !== exp) begin
         bad++;
         $display("FAIL %s: state got %0d expected %0d", name, dut.state_q, exp);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      total++;
      if ({tick, out_valid, out_data, out_perr, overrun, fifo_count} !== 16'h0) begin
         bad++;
         $display("FAIL %s: tick=%b valid=%b data=%h perr=%b ovr=%b cnt=%0d expected all zero",
                  name, tick, out_valid, out_data, out_perr, overrun, fifo_count);
      end
      check_state(name, IDLE);
   endtask

   task automatic go_run();
      enable = 1'b1;
      step();
      mrun = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      check_reset_outputs("reset");
   endtask

   task automatic test_tick();
      logic exp;
      baud_div = 16'd3;
      enable = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         step();
         mrun = 1'b1;
         exp = i >= 5 && (i - 5) % 4 == 0;
         total++;
         if (tick !== exp) begin
            bad++;
            $display("FAIL tick_run: cycle %0d got %b expected %b", i, tick, exp);
         end
      end
      enable = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         step();
         mrun = 1'b0;
         total++;
         if (tick !== 1'b0) begin
            bad++;
            $display("FAIL tick_off: cycle %0d got %b expected 0", i, tick);
         end
         if (i == 2) check_state("drain_to_idle", IDLE);
      end
   endtask

   task automatic test_order();
      go_run();
      send(8'h41, 1'b0); send(8'h42, 1'b0); send(8'h43, 1'b0);
      out_ready = 1'b1;
      repeat (3) step();
      out_ready = 1'b0;
      step();
   endtask

   task automatic test_drain();
      send(8'h10, 1'b0); send(8'h11, 1'b0);
      enable = 1'b0;
      step();
      mrun = 1'b0;
      check_state("drain_hold", DRAIN);
      send(8'hEE, 1'b0);
      out_ready = 1'b1;
      repeat (2) step();
      out_ready = 1'b0;
      step();
      check_state("drain_empty_idle", IDLE);
      go_run();
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 9; i++) send(8'(8'h60 + i), 1'b0);
      clr_overrun = 1'b1;
      step();
      clr_overrun = 1'b0;
      out_ready = 1'b1;
      repeat (8) step();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(8'(8'h70 + i), 1'b0);
      out_ready = 1'b1;
      send(8'h78, 1'b0);
      repeat (8) step();
      out_ready = 1'b0;
   endtask

   task automatic test_perr();
      send(8'h55, 1'b1);
      total++;
      if (out_perr !== 1'b1 || out_data !== 8'h55) begin
         bad++;
         $display("FAIL perr_head: got perr=%b data=%h expected 1/55", out_perr, out_data);
      end
      out_ready = 1'b1;
      step();
`ifdef UART_RX_ERR_CNT_EN
      for (int i = 0; i < 300; i++) send(8'(i), 1'b1);
      step();
      total++;
      if (err_cnt !== 8'd255) begin
         bad++;
         $display("FAIL err_sat: got %0d expected 255", err_cnt);
      end
`endif
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 9; i++) send(8'(8'h80 + i), 1'b0);
      out_ready = 1'b1;
      repeat (3) step();
      out_ready = 1'b0;
      flush = 1'b1; rx_done = 1'b1; rx_data = 8'hAA;
      step();
      flush = 1'b0; rx_done = 1'b0;
      total++;
      if (fifo_count !== 4'd0 || out_valid !== 1'b0 || overrun !== 1'b1) begin
         bad++;
         $display("FAIL flush: got cnt=%0d valid=%b ovr=%b expected 0/0/1", fifo_count, out_valid, overrun);
      end
      clr_overrun = 1'b1;
      step();
      clr_overrun = 1'b0;
   endtask

   task automatic test_reset_run();
      for (int i = 0; i < 9; i++) send(8'(8'h90 + i), i[0]);
      out_ready = 1'b1;
      repeat (5) step();
      out_ready = 1'b0;
      rst = 1'b1; enable = 1'b0;
      step();
      mrun = 1'b0;
      rst = 1'b0;
      check_reset_outputs("reset_in_run");
      step();
      check_reset_outputs("reset_after");
   endtask

   initial begin
      test_reset();
      test_tick();
      test_order();
      test_drain();
      test_overrun();
      test_perr();
      test_flush();
      test_reset_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
